// File: rtl/key_conditioner.sv
// Washer panel key conditioner: per-key 2-flop synchroniser, tick-based debounce and a
// hold FSM producing one-cycle press/release/long/repeat strobes.
module key_conditioner #(
    parameter int N_KEYS         = 5,
    parameter int ACTIVE_LOW     = 0,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              tick
);

    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [PW-1:0]     PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]     DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0]     LONG_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0]     REP_LAST  = HW'(REPEAT_TICKS - 1);
    localparam logic [N_KEYS-1:0] RAW_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} ch_state_t;

    logic [PW-1:0]     pre_cnt;
    logic [N_KEYS-1:0] sync_q1, sync_q2, s;
    logic [DW-1:0]     deb_cnt [N_KEYS];
    logic [N_KEYS-1:0] accept, press_acc, rel_acc;
    ch_state_t         state     [N_KEYS];
    ch_state_t         state_nxt [N_KEYS];
    logic [HW-1:0]     hold_cnt  [N_KEYS];
    logic [HW-1:0]     hold_nxt  [N_KEYS];
    logic [N_KEYS-1:0] long_nxt, repeat_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)                  pre_cnt <= '0;
        else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
        else                         pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick = (pre_cnt == PRE_LAST);

    // Synchroniser resets to the released level so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= RAW_IDLE;
            sync_q2 <= RAW_IDLE;
        end else begin
            sync_q1 <= key_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2 ^ RAW_IDLE;

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_KEYS; i++)
            accept[i] = tick && (s[i] != key_level[i]) && (deb_cnt[i] == DEB_LAST);
    end

    assign press_acc = accept & ~key_level;
    assign rel_acc   = accept &  key_level;

    // NOTE: the small per-key counter arrays are flops, so they are reset like any other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) deb_cnt[i] <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if ((s[i] == key_level[i]) || accept[i]) deb_cnt[i] <= '0;
                else if (tick)                           deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
            key_level   <= key_level ^ accept;
            key_press   <= press_acc;
            key_release <= rel_acc;
        end
    end

    always_comb begin
        long_nxt   = '0;
        repeat_nxt = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold_cnt[i];
            case (state[i])
                ST_IDLE: begin
                    if (press_acc[i]) begin
                        state_nxt[i] = ST_HELD;
                        hold_nxt[i]  = '0;
                    end
                end
                ST_HELD: begin
                    // A release on the threshold tick wins and suppresses the long strobe.
                    if (rel_acc[i]) begin
                        state_nxt[i] = ST_IDLE;
                        hold_nxt[i]  = '0;
                    end else if (tick) begin
                        if (hold_cnt[i] == LONG_LAST) begin
                            long_nxt[i]  = 1'b1;
                            hold_nxt[i]  = '0;
                            state_nxt[i] = ST_LONG;
                        end else begin
                            hold_nxt[i] = hold_cnt[i] + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    if (rel_acc[i]) begin
                        state_nxt[i] = ST_IDLE;
                        hold_nxt[i]  = '0;
                    end else if (tick) begin
                        if (hold_cnt[i] == REP_LAST) begin
                            repeat_nxt[i] = 1'b1;
                            hold_nxt[i]   = '0;
                        end else begin
                            hold_nxt[i] = hold_cnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    hold_nxt[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state[i]    <= ST_IDLE;
                hold_cnt[i] <= '0;
            end
            key_long   <= '0;
            key_repeat <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state[i]    <= state_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
            end
            key_long   <= long_nxt;
            key_repeat <= repeat_nxt;
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a tick-numbered reference model queues expected
// strobe events; a negedge monitor pops and compares them against the DUT.
module tb_key_conditioner;

    localparam int NK = 5;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int LT = 5;
    localparam int RT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;
    logic          tick;

    always #5 clk = ~clk;

    key_conditioner #(
        .N_KEYS(NK), .ACTIVE_LOW(0), .TICK_DIV(TD),
        .DEBOUNCE_TICKS(DB), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat), .tick(tick)
    );

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] rep;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: events derived from tick numbers since reset.
    int            edge_no = 0;
    int            r_edge  = 0;
    int            tick_no = 0;
    int            t, held;
    bit            t_now;
    bit            exp_tick = 1'b0;
    logic [NK-1:0] hist [int];
    logic [NK-1:0] s_m;
    logic [NK-1:0] m_level = '0;
    bit   [NK-1:0] pend    = '0;
    int            pstart   [NK];
    int            acc_tick [NK];
    ev_t           ev;
    int            mod_press_n = 0, mod_rel_n = 0, mod_long_n = 0, mod_rep_n = 0;

    always @(posedge clk) begin
        edge_no++;
        hist[edge_no] = key_raw;
        if (!rst_n) begin
            r_edge   = edge_no;
            tick_no  = 0;
            m_level  = '0;
            pend     = '0;
            exp_tick = 1'b0;
        end else begin
            // The cycle just ending is edge_no-1; its synchronised input is the raw
            // value sampled two edges back (released level right after reset).
            t_now = (((edge_no - 1 - r_edge) % TD) == TD - 1);
            s_m   = (edge_no - 2 > r_edge) ? hist[edge_no - 2] : '0;
            t     = tick_no + (t_now ? 1 : 0);
            ev.cyc = edge_no; ev.press = '0; ev.rel = '0; ev.lng = '0; ev.rep = '0;
            for (int k = 0; k < NK; k++) begin
                if (s_m[k] == m_level[k]) begin
                    pend[k] = 1'b0;
                end else begin
                    if (!pend[k]) begin
                        pend[k]   = 1'b1;
                        pstart[k] = tick_no;
                    end
                    if (t_now && (t - pstart[k]) == DB) begin
                        if (m_level[k]) ev.rel[k] = 1'b1;
                        else begin
                            ev.press[k] = 1'b1;
                            acc_tick[k] = t;
                        end
                        m_level[k] = ~m_level[k];
                        pend[k]    = 1'b0;
                    end
                end
                if (t_now && m_level[k] && !ev.press[k]) begin
                    held = t - acc_tick[k];
                    if (held == LT) ev.lng[k] = 1'b1;
                    else if (held > LT && ((held - LT) % RT) == 0) ev.rep[k] = 1'b1;
                end
            end
            tick_no = t;
            if ((ev.press | ev.rel | ev.lng | ev.rep) != '0) begin
                exp_q.push_back(ev);
                mod_press_n += $countones(ev.press);
                mod_rel_n   += $countones(ev.rel);
                mod_long_n  += $countones(ev.lng);
                mod_rep_n   += $countones(ev.rep);
            end
            exp_tick = (((edge_no - r_edge) % TD) == TD - 1);
        end
    end

    // Monitor
    ev_t e;
    int  dut_press_n = 0, dut_rel_n = 0, dut_long_n = 0, dut_rep_n = 0;

    always @(negedge clk) begin
        if (edge_no > 0) begin
            check("key_level", 32'(key_level), 32'(m_level));
            check("tick", 32'(tick), 32'(exp_tick));
            dut_press_n += $countones(key_press);
            dut_rel_n   += $countones(key_release);
            dut_long_n  += $countones(key_long);
            dut_rep_n   += $countones(key_repeat);
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_no) begin
                checks++;
                failures++;
                $display("FAIL missed_event: expected at edge %0d, now edge %0d", exp_q[0].cyc, edge_no);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_no) begin
                e = exp_q.pop_front();
                check("key_press",   32'(key_press),   32'(e.press));
                check("key_release", 32'(key_release), 32'(e.rel));
                check("key_long",    32'(key_long),    32'(e.lng));
                check("key_repeat",  32'(key_repeat),  32'(e.rep));
            end else begin
                check("no_strobe", 32'({key_press, key_release, key_long, key_repeat}), 32'd0);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int kk;

    initial begin
        rst_n   = 1'b0;
        key_raw = '1;
        run(3);
        rst_n   = 1'b1;
        key_raw = '0;
        run(20);

        // Clean press and release on key0
        key_raw[0] = 1'b1; run(40);
        key_raw[0] = 1'b0; run(30);

        // Bouncing key1 never settles long enough
        for (int i = 0; i < 6; i++) begin
            key_raw[1] = ~key_raw[1];
            run(5);
        end
        key_raw[1] = 1'b0; run(30);

        // Long hold on key2 with auto-repeat
        key_raw[2] = 1'b1; run(60 * TD);
        key_raw[2] = 1'b0; run(40);

        // Simultaneous press on key3 and key4
        key_raw[4:3] = 2'b11; run(60);
        key_raw[4:3] = 2'b00; run(40);

        // Reset while key0 is in long hold
        key_raw[0] = 1'b1; run(TD * (DB + LT + RT) + 20);
        pulse_reset();
        run(40);
        key_raw[0] = 1'b0; run(40);

        // Randomised toggling with occasional resets
        for (int i = 0; i < 400; i++) begin
            kk = $urandom_range(NK - 1, 0);
            key_raw[kk] = ~key_raw[kk];
            run($urandom_range(50, 1));
            if ($urandom_range(59, 0) == 0) pulse_reset();
        end

        key_raw = '0;
        run(60);

        check("press_total",   32'(dut_press_n), 32'(mod_press_n));
        check("release_total", 32'(dut_rel_n),   32'(mod_rel_n));
        check("long_total",    32'(dut_long_n),  32'(mod_long_n));
        check("repeat_total",  32'(dut_rep_n),   32'(mod_rep_n));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
